// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID/EX hazard unit and the pipeline: operand/stage address inputs,
// forwarding selects, stall and multi-cycle scoreboard status.
interface hazard_forward_unit_if #(
  parameter int NSRC = 2,
  parameter int NSTG = 2,
  parameter int RW   = 5,
  parameter int MCW  = 6
);
  localparam int SW = $clog2(NSTG + 1);

  logic [NSRC*RW-1:0] id_rs_i;
  logic [NSRC-1:0]    id_rs_used_i;
  logic [NSTG*RW-1:0] stg_rd_i;
  logic [NSTG-1:0]    stg_wen_i;
  logic [NSTG-1:0]    stg_load_i;
  logic               hold_i;
  logic               mc_start_i;
  logic [RW-1:0]      mc_rd_i;
  logic [MCW-1:0]     mc_lat_i;
  logic [NSRC*SW-1:0] fwd_sel_o;
  logic               stall_o;
  logic               mc_busy_o;
  logic               mc_done_o;
  logic               err_o;

  modport master (
    output id_rs_i, id_rs_used_i, stg_rd_i, stg_wen_i, stg_load_i, hold_i,
           mc_start_i, mc_rd_i, mc_lat_i,
    input  fwd_sel_o, stall_o, mc_busy_o, mc_done_o, err_o
  );

  modport slave (
    input  id_rs_i, id_rs_used_i, stg_rd_i, stg_wen_i, stg_load_i, hold_i,
           mc_start_i, mc_rd_i, mc_lat_i,
    output fwd_sel_o, stall_o, mc_busy_o, mc_done_o, err_o
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, load-use stall counter and a single-entry scoreboard
// for one multi-cycle functional unit, sitting beside the ID/EX boundary.
module hazard_forward_unit #(
  parameter int NSRC  = 2,
  parameter int NSTG  = 2,
  parameter int RW    = 5,
  parameter int LDLAT = 1,
  parameter int MCW   = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  hazard_forward_unit_if.slave  bus
);
  localparam int SW = $clog2(NSTG + 1);
  localparam int LW = (LDLAT > 1) ? $clog2(LDLAT) : 1;

  typedef enum logic {LU_IDLE, LU_COUNT} lu_state_t;
  typedef enum logic {MC_IDLE, MC_BUSY}  mc_state_t;

  lu_state_t        lu_state_q, lu_state_d;
  logic [LW-1:0]    lu_cnt_q, lu_cnt_d;
  mc_state_t        mc_state_q, mc_state_d;
  logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
  logic [RW-1:0]    mc_rd_q, mc_rd_d;
  logic             mc_done_q, mc_done_d;
  logic             err_q, err_d;

  logic [NSRC*SW-1:0] fwd_sel;
  logic [NSRC-1:0]    lu_hit_k;
  logic [NSRC-1:0]    mc_hit_k;
  logic               lu_hit;
  logic               mc_busy;
  logic               waw_hit;
  logic               mc_hit;
  logic [MCW-1:0]     mc_lat_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [RW-1:0] rs;
      logic [SW-1:0] sel;
      logic          used;

      assign rs   = bus.id_rs_i[gi*RW +: RW];
      assign used = bus.id_rs_used_i[gi];

      // Scan furthest-to-nearest so the nearest matching stage wins.
      always_comb begin
        sel = '0;
        for (int j = NSTG; j >= 1; j--) begin
          if (bus.stg_wen_i[j-1] && (bus.stg_rd_i[(j-1)*RW +: RW] == rs) && (rs != '0)) begin
            sel = SW'(j);
          end
        end
      end

      assign fwd_sel[gi*SW +: SW] = sel;
      assign lu_hit_k[gi] = used && (sel == SW'(1)) && bus.stg_load_i[0];
      assign mc_hit_k[gi] = used && (rs != '0) && (rs == mc_rd_q);
    end

    if (NSTG > 1) begin : g_unused_load
      logic unused_load;
      assign unused_load = ^bus.stg_load_i[NSTG-1:1];
    end
  endgenerate

  assign lu_hit     = |lu_hit_k;
  assign mc_busy    = (mc_state_q == MC_BUSY);
  assign waw_hit    = bus.stg_wen_i[0] && (bus.stg_rd_i[RW-1:0] == mc_rd_q);
  assign mc_hit     = mc_busy && ((|mc_hit_k) || waw_hit);
  assign mc_lat_eff = (bus.mc_lat_i == '0) ? MCW'(1) : bus.mc_lat_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lu_state_q <= LU_IDLE;
      lu_cnt_q   <= '0;
      mc_state_q <= MC_IDLE;
      mc_cnt_q   <= '0;
      mc_rd_q    <= '0;
      mc_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lu_state_q <= lu_state_d;
      lu_cnt_q   <= lu_cnt_d;
      mc_state_q <= mc_state_d;
      mc_cnt_q   <= mc_cnt_d;
      mc_rd_q    <= mc_rd_d;
      mc_done_q  <= mc_done_d;
      err_q      <= err_d;
    end
  end

  // The load-use bubble already counts as the first stall cycle, so LDLAT-1 remain.
  always_comb begin
    lu_state_d = lu_state_q;
    lu_cnt_d   = lu_cnt_q;
    case (lu_state_q)
      LU_IDLE: begin
        if (lu_hit && !bus.hold_i && (LDLAT > 1)) begin
          lu_cnt_d   = LW'(LDLAT - 1);
          lu_state_d = LU_COUNT;
        end
      end
      LU_COUNT: begin
        if (!bus.hold_i) begin
          lu_cnt_d = lu_cnt_q - LW'(1);
          if (lu_cnt_q == LW'(1)) begin
            lu_state_d = LU_IDLE;
          end
        end
      end
      default: lu_state_d = LU_IDLE;
    endcase
  end

  always_comb begin
    mc_state_d = mc_state_q;
    mc_cnt_d   = mc_cnt_q;
    mc_rd_d    = mc_rd_q;
    mc_done_d  = 1'b0;
    err_d      = err_q;
    case (mc_state_q)
      MC_IDLE: begin
        if (bus.mc_start_i) begin
          mc_cnt_d   = mc_lat_eff;
          mc_rd_d    = bus.mc_rd_i;
          mc_state_d = MC_BUSY;
        end
      end
      MC_BUSY: begin
        mc_cnt_d = mc_cnt_q - MCW'(1);
        if (mc_cnt_q == MCW'(1)) begin
          mc_done_d = 1'b1;
          // A start landing on the final cycle chains straight into a new op.
          if (bus.mc_start_i) begin
            mc_cnt_d = mc_lat_eff;
            mc_rd_d  = bus.mc_rd_i;
          end else begin
            mc_state_d = MC_IDLE;
          end
        end else if (bus.mc_start_i) begin
          err_d = 1'b1;
        end
      end
      default: mc_state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    bus.fwd_sel_o = reset_i ? '0 : fwd_sel;
    bus.stall_o   = !reset_i && (lu_hit || (lu_state_q == LU_COUNT) || mc_hit);
    bus.mc_busy_o = mc_busy;
    bus.mc_done_o = mc_done_q;
    bus.err_o     = err_q;
  end
endmodule
